// File: rtl/mem_bus_arbiter.sv
// Two-requester arbiter and 3-phase sequencer for the byte-wide external memory bus.
// Phases: A1 (addr low/mid), A2 (addr high + direction marker), D (data), then a TURN cycle.
module mem_bus_arbiter #(
    parameter bit         ROUND_ROBIN = 1'b1,
    parameter logic [7:0] RD_MARK     = 8'h00,
    parameter logic [7:0] WR_MARK     = 8'hFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req,
    input  logic [1:0]  we,
    input  logic [23:0] addr0,
    input  logic [23:0] addr1,
    input  logic [7:0]  wdata0,
    input  logic [7:0]  wdata1,
    output logic [1:0]  gnt,
    output logic [1:0]  done,
    output logic [7:0]  rdata,
    output logic [7:0]  bus_lo,
    output logic [7:0]  bus_hi,
    output logic [7:0]  bus_oe,
    input  logic [7:0]  bus_in
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_A1   = 3'd1,
        S_A2   = 3'd2,
        S_D    = 3'd3,
        S_TURN = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  gnt_q, gnt_d;
    logic [1:0]  done_q, done_d;
    logic [7:0]  rdata_q, rdata_d;
    logic [7:0]  bus_lo_q, bus_lo_d;
    logic [7:0]  bus_hi_q, bus_hi_d;
    logic        last_grant_q, last_grant_d;
    logic        sel_q, sel_d;
    logic        we_q, we_d;
    logic [23:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        win;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            gnt_q        <= '0;
            done_q       <= '0;
            rdata_q      <= '0;
            bus_lo_q     <= '0;
            bus_hi_q     <= '0;
            last_grant_q <= 1'b1;
            sel_q        <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            done_q       <= done_d;
            rdata_q      <= rdata_d;
            bus_lo_q     <= bus_lo_d;
            bus_hi_q     <= bus_hi_d;
            last_grant_q <= last_grant_d;
            sel_q        <= sel_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
        end
    end

    // Tie-break: round robin favours the requester not granted last time.
    always_comb begin
        win = 1'b0;
        case (req)
            2'b01:   win = 1'b0;
            2'b10:   win = 1'b1;
            2'b11:   win = ROUND_ROBIN ? ~last_grant_q : 1'b0;
            default: win = 1'b0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        done_d       = done_q;
        rdata_d      = rdata_q;
        bus_lo_d     = bus_lo_q;
        bus_hi_d     = bus_hi_q;
        last_grant_d = last_grant_q;
        sel_d        = sel_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;

        case (state_q)
            S_IDLE: begin
                gnt_d    = '0;
                done_d   = '0;
                bus_lo_d = '0;
                bus_hi_d = '0;
                if (req != 2'b00) begin
                    sel_d        = win;
                    last_grant_d = win;
                    we_d         = we[win];
                    addr_d       = win ? addr1 : addr0;
                    wdata_d      = win ? wdata1 : wdata0;
                    gnt_d        = win ? 2'b10 : 2'b01;
                    bus_lo_d     = win ? addr1[7:0]  : addr0[7:0];
                    bus_hi_d     = win ? addr1[15:8] : addr0[15:8];
                    state_d      = S_A1;
                end
            end
            S_A1: begin
                bus_lo_d = addr_q[23:16];
                bus_hi_d = we_q ? WR_MARK : RD_MARK;
                state_d  = S_A2;
            end
            S_A2: begin
                bus_lo_d = we_q ? wdata_q : 8'h00;
                bus_hi_d = we_q ? WR_MARK : RD_MARK;
                state_d  = S_D;
            end
            S_D: begin
                if (!we_q) begin
                    rdata_d = bus_in;
                end
                bus_lo_d = '0;
                bus_hi_d = '0;
                done_d   = sel_q ? 2'b10 : 2'b01;
                state_d  = S_TURN;
            end
            S_TURN: begin
                gnt_d   = '0;
                done_d  = '0;
                state_d = S_IDLE;
            end
            default: begin
                gnt_d    = '0;
                done_d   = '0;
                bus_lo_d = '0;
                bus_hi_d = '0;
                state_d  = S_IDLE;
            end
        endcase
    end

    assign gnt    = gnt_q;
    assign done   = done_q;
    assign rdata  = rdata_q;
    assign bus_lo = bus_lo_q;
    assign bus_hi = bus_hi_q;
    assign bus_oe = 8'hFF;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: table of single transactions plus hand-written corner sequences.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req;
    logic [1:0]  we;
    logic [23:0] addr0, addr1;
    logic [7:0]  wdata0, wdata1;
    logic [7:0]  bus_in;

    logic [1:0]  gnt, done;
    logic [7:0]  rdata, bus_lo, bus_hi, bus_oe;
    logic [1:0]  gnt_fp, done_fp;
    logic [7:0]  rdata_fp, bus_lo_fp, bus_hi_fp, bus_oe_fp;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.ROUND_ROBIN(1'b1), .RD_MARK(8'h00), .WR_MARK(8'hFF)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt(gnt), .done(done), .rdata(rdata),
        .bus_lo(bus_lo), .bus_hi(bus_hi), .bus_oe(bus_oe), .bus_in(bus_in)
    );

    mem_bus_arbiter #(.ROUND_ROBIN(1'b0), .RD_MARK(8'h00), .WR_MARK(8'hFF)) dut_fp (
        .clk(clk), .rst(rst), .req(req), .we(we),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt(gnt_fp), .done(done_fp), .rdata(rdata_fp),
        .bus_lo(bus_lo_fp), .bus_hi(bus_hi_fp), .bus_oe(bus_oe_fp), .bus_in(bus_in)
    );

    typedef struct {
        logic [1:0]  req;
        logic [1:0]  we;
        logic [23:0] a0;
        logic [23:0] a1;
        logic [7:0]  w0;
        logic [7:0]  w1;
        logic [7:0]  bin;
        logic [1:0]  g;
        logic [7:0]  lo1, hi1, lo2, hi2, lo3, hi3;
        logic [7:0]  rd;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Drives one transaction from IDLE and checks every phase; req drops after done is seen.
    task automatic run_vec(input vec_t v);
        req = v.req; we = v.we; addr0 = v.a0; addr1 = v.a1;
        wdata0 = v.w0; wdata1 = v.w1; bus_in = v.bin;
        @(posedge clk); #1;
        chk("a1_gnt", {22'd0, gnt}, {22'd0, v.g});
        chk("a1_lo", {16'd0, bus_lo}, {16'd0, v.lo1});
        chk("a1_hi", {16'd0, bus_hi}, {16'd0, v.hi1});
        @(posedge clk); #1;
        chk("a2_lo", {16'd0, bus_lo}, {16'd0, v.lo2});
        chk("a2_hi", {16'd0, bus_hi}, {16'd0, v.hi2});
        @(posedge clk); #1;
        chk("d_lo", {16'd0, bus_lo}, {16'd0, v.lo3});
        chk("d_hi", {16'd0, bus_hi}, {16'd0, v.hi3});
        chk("d_done", {22'd0, done}, 24'd0);
        @(posedge clk); #1;
        chk("turn_done", {22'd0, done}, {22'd0, v.g});
        chk("turn_gnt", {22'd0, gnt}, {22'd0, v.g});
        chk("turn_rdata", {16'd0, rdata}, {16'd0, v.rd});
        chk("turn_bus", {8'd0, bus_lo, bus_hi}, 24'd0);
        req = 2'b00;
        @(posedge clk); #1;
        chk("idle_gnt", {22'd0, gnt}, 24'd0);
        chk("idle_done", {22'd0, done}, 24'd0);
    endtask

    initial begin
        //          req    we     a0          a1          w0     w1     bin    g      lo1    hi1    lo2    hi2    lo3    hi3    rd
        vecs[0] = '{2'b01, 2'b00, 24'h000001, 24'h000000, 8'h00, 8'h00, 8'h05, 2'b01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h05};
        vecs[1] = '{2'b10, 2'b10, 24'h000000, 24'h800002, 8'h00, 8'hAB, 8'hEE, 2'b10, 8'h02, 8'h00, 8'h80, 8'hFF, 8'hAB, 8'hFF, 8'h05};
        vecs[2] = '{2'b10, 2'b00, 24'h000000, 24'h123456, 8'h00, 8'h00, 8'h3C, 2'b10, 8'h56, 8'h34, 8'h12, 8'h00, 8'h00, 8'h00, 8'h3C};
        vecs[3] = '{2'b01, 2'b01, 24'hA5B6C7, 24'h000000, 8'h5A, 8'h00, 8'h99, 2'b01, 8'hC7, 8'hB6, 8'hA5, 8'hFF, 8'h5A, 8'hFF, 8'h3C};

        rst = 1'b1; req = '0; we = '0; addr0 = '0; addr1 = '0;
        wdata0 = '0; wdata1 = '0; bus_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt", {22'd0, gnt}, 24'd0);
        chk("rst_done", {22'd0, done}, 24'd0);
        chk("rst_rdata", {16'd0, rdata}, 24'd0);
        chk("rst_bus", {8'd0, bus_lo, bus_hi}, 24'd0);
        chk("bus_oe", {16'd0, bus_oe}, 24'h0000FF);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            run_vec(vecs[i]);
        end

        // Back-to-back: idle cycle with req low must not regrant, then the next request is fresh.
        run_vec('{2'b01, 2'b00, 24'h000001, 24'h0, 8'h00, 8'h00, 8'h11, 2'b01,
                  8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h11});
        @(posedge clk); #1;
        chk("b2b_no_dup", {22'd0, gnt}, 24'd0);
        run_vec('{2'b01, 2'b00, 24'h000002, 24'h0, 8'h00, 8'h00, 8'h22, 2'b01,
                  8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h22});

        // Field change after the grant edge: latched address must still be used.
        req = 2'b01; we = 2'b00; addr0 = 24'h000003; bus_in = 8'h77;
        @(posedge clk); #1;
        addr0 = 24'hFFFFFF; req = 2'b00;
        chk("fc_gnt", {22'd0, gnt}, 24'd1);
        chk("fc_a1", {8'd0, bus_lo, bus_hi}, 24'h000300);
        @(posedge clk); #1;
        chk("fc_a2", {8'd0, bus_lo, bus_hi}, 24'h000000);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("fc_done", {22'd0, done}, 24'd1);
        chk("fc_rdata", {16'd0, rdata}, 24'h000077);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("fc_no_regrant", {22'd0, gnt}, 24'd0);

        // Contention from reset: RR alternates, fixed priority keeps requester 0.
        rst = 1'b1; #2; rst = 1'b0;
        req = 2'b11; we = 2'b00; addr0 = 24'h000010; addr1 = 24'h000020;
        for (int g = 0; g < 4; g++) begin
            @(posedge clk); #1;
            chk("rr_gnt", {22'd0, gnt}, (g % 2 == 0) ? 24'd1 : 24'd2);
            chk("fp_gnt", {22'd0, gnt_fp}, 24'd1);
            repeat (4) @(posedge clk);
            #1;
            chk("rr_idle", {22'd0, gnt}, 24'd0);
        end
        req = 2'b00;

        // Async reset in the D cycle of a write, then re-grant of the still-pending request.
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        req = 2'b01; we = 2'b01; addr0 = 24'h112233; wdata0 = 8'h44;
        @(posedge clk); #1;
        chk("ar_a1_gnt", {22'd0, gnt}, 24'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("ar_d_bus", {8'd0, bus_lo, bus_hi}, 24'h0044FF);
        #3 rst = 1'b1;
        #1;
        chk("ar_gnt", {22'd0, gnt}, 24'd0);
        chk("ar_done", {22'd0, done}, 24'd0);
        chk("ar_bus", {8'd0, bus_lo, bus_hi}, 24'd0);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        chk("ar_regrant", {22'd0, gnt}, 24'd1);
        chk("ar_regrant_a1", {8'd0, bus_lo, bus_hi}, 24'h003322);
        chk("ar_regrant_done", {22'd0, done}, 24'd0);
        @(posedge clk); #1;
        chk("ar_a2", {8'd0, bus_lo, bus_hi}, 24'h0011FF);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("ar_turn_done", {22'd0, done}, 24'd1);
        req = 2'b00;
        @(posedge clk); #1;
        chk("ar_idle", {22'd0, gnt}, 24'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
